// File: rtl/wired_mask_assemble.sv
// wired_mask_assemble: assembles a WIDTH-bit mask from a stream of index beats, with dup/err flags and set-bit count
module wired_mask_assemble #(
   parameter int WIDTH = 8,
   parameter logic MODE = 1'b0,
   localparam int CNT_WIDTH = $clog2(WIDTH),
   localparam int POP_WIDTH = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush_i,
   input  logic                 idx_valid_i,
   output logic                 idx_ready_o,
   input  logic [CNT_WIDTH-1:0] idx_i,
   input  logic                 idx_empty_i,
   input  logic                 idx_last_i,
   output logic                 mask_valid_o,
   input  logic                 mask_ready_i,
   output logic [WIDTH-1:0]     mask_o,
   output logic [POP_WIDTH-1:0] mask_cnt_o,
   output logic                 mask_dup_o,
   output logic                 mask_err_o
);
   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;
   logic [0:0]           state_q, state_d;
   logic [WIDTH-1:0]     acc_q, acc_d, onehot;
   logic [POP_WIDTH-1:0] cnt_q, cnt_d;
   logic                 dup_q, dup_d, err_q, err_d;
   logic                 accept, release_mask, out_of_range, is_dup, is_new;
   // out-of-range indices match no bit position, so onehot is zero for them
   for (genvar i = 0; i < WIDTH; i++) begin : g_hot
      assign onehot[i] = !idx_empty_i && (idx_i == CNT_WIDTH'(MODE ? WIDTH - 1 - i : i));
   end
   assign accept       = idx_valid_i && state_q == ACCUM;
   assign release_mask = mask_ready_i && state_q == HOLD;
   assign out_of_range = !idx_empty_i && ({1'b0, idx_i} >= (CNT_WIDTH + 1)'(WIDTH));
   assign is_dup       = |(onehot & acc_q);
   assign is_new       = |(onehot & ~acc_q);
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dup_d   = dup_q;
      err_d   = err_q;
      if (accept) begin
         acc_d   = acc_q | onehot;
         cnt_d   = cnt_q + POP_WIDTH'(is_new);
         dup_d   = dup_q | is_dup;
         err_d   = err_q | out_of_range;
         state_d = idx_last_i ? HOLD : ACCUM;
      end
      if (release_mask || flush_i) begin
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
         dup_d   = 1'b0;
         err_d   = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         dup_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         dup_q   <= dup_d;
         err_q   <= err_d;
      end
   end
   assign idx_ready_o  = state_q == ACCUM;
   assign mask_valid_o = state_q == HOLD;
   assign mask_o       = acc_q;
   assign mask_cnt_o   = cnt_q;
   assign mask_dup_o   = dup_q;
   assign mask_err_o   = err_q;
endmodule

// File: tb/tb_wired_mask_assemble.sv
// tb_wired_mask_assemble: directed checks of the mask assembler in three configurations sharing one stimulus stream
module tb_wired_mask_assemble;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush_i = 1'b0;
   logic       idx_valid_i = 1'b0;
   logic [2:0] idx_i = '0;
   logic       idx_empty_i = 1'b0;
   logic       idx_last_i = 1'b0;
   logic       mask_ready_i = 1'b0;
   logic       rdy0, rdy1, rdy2, val0, val1, val2;
   logic [7:0] mask0, mask1;
   logic [5:0] mask2;
   logic [3:0] cnt0, cnt1;
   logic [2:0] cnt2;
   logic       dup0, dup1, dup2, err0, err1, err2;
   int         n_tests = 0;
   int         n_fail = 0;
   always #5 clk = ~clk;
   wired_mask_assemble #(.WIDTH(8), .MODE(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .idx_valid_i(idx_valid_i), .idx_ready_o(rdy0),
      .idx_i(idx_i), .idx_empty_i(idx_empty_i), .idx_last_i(idx_last_i), .mask_valid_o(val0),
      .mask_ready_i(mask_ready_i), .mask_o(mask0), .mask_cnt_o(cnt0), .mask_dup_o(dup0), .mask_err_o(err0));
   wired_mask_assemble #(.WIDTH(8), .MODE(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .idx_valid_i(idx_valid_i), .idx_ready_o(rdy1),
      .idx_i(idx_i), .idx_empty_i(idx_empty_i), .idx_last_i(idx_last_i), .mask_valid_o(val1),
      .mask_ready_i(mask_ready_i), .mask_o(mask1), .mask_cnt_o(cnt1), .mask_dup_o(dup1), .mask_err_o(err1));
   wired_mask_assemble #(.WIDTH(6), .MODE(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .idx_valid_i(idx_valid_i), .idx_ready_o(rdy2),
      .idx_i(idx_i), .idx_empty_i(idx_empty_i), .idx_last_i(idx_last_i), .mask_valid_o(val2),
      .mask_ready_i(mask_ready_i), .mask_o(mask2), .mask_cnt_o(cnt2), .mask_dup_o(dup2), .mask_err_o(err2));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic beat(input logic [2:0] i, input logic e, input logic l);
      idx_valid_i = 1'b1;
      idx_i       = i;
      idx_empty_i = e;
      idx_last_i  = l;
      @(posedge clk);
      #1 idx_valid_i = 1'b0;
      idx_empty_i = 1'b0;
      idx_last_i  = 1'b0;
   endtask
   task automatic take();
      mask_ready_i = 1'b1;
      @(posedge clk);
      #1 mask_ready_i = 1'b0;
   endtask
   task automatic pulse_flush();
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
   endtask
   initial begin
      #3;
      check("rst_valid", val0, 0);
      check("rst_mask", mask0, 0);
      check("rst_cnt", cnt0, 0);
      #14 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_ready", rdy0, 1);
      check("post_rst_valid", val0, 0);
      beat(3'd0, 1'b0, 1'b0);
      check("live_mask", mask0, 8'h01);
      check("live_valid", val0, 0);
      beat(3'd3, 1'b0, 1'b1);
      check("m0_valid", val0, 1);
      check("m0_ready", rdy0, 0);
      check("m0_mask", mask0, 8'h09);
      check("m0_cnt", cnt0, 2);
      check("m0_dup", dup0, 0);
      check("m0_err", err0, 0);
      check("m1_mask_msb", mask1, 8'h90);
      check("w6_mask", mask2, 6'h09);
      take();
      check("take_valid", val0, 0);
      check("take_mask", mask0, 0);
      check("take_ready", rdy0, 1);
      beat(3'd0, 1'b0, 1'b1);
      check("msb0_mask", mask1, 8'h80);
      check("msb0_cnt", cnt1, 1);
      check("lsb0_mask", mask0, 8'h01);
      take();
      beat(3'd5, 1'b1, 1'b1);
      check("empty_valid", val1, 1);
      check("empty_mask", mask1, 8'h00);
      check("empty_cnt", cnt1, 0);
      check("empty_dup", dup1, 0);
      check("empty_err", err1, 0);
      take();
      beat(3'd3, 1'b0, 1'b0);
      beat(3'd3, 1'b0, 1'b1);
      check("dup_mask", mask0, 8'h08);
      check("dup_cnt", cnt0, 1);
      check("dup_flag", dup0, 1);
      take();
      beat(3'd7, 1'b0, 1'b0);
      check("err_live_w6", mask2, 6'h00);
      beat(3'd2, 1'b0, 1'b1);
      check("err_mask_w6", mask2, 6'h04);
      check("err_cnt_w6", cnt2, 1);
      check("err_flag_w6", err2, 1);
      check("err_dup_w6", dup2, 0);
      check("noerr_w8_mask", mask0, 8'h84);
      check("noerr_w8_err", err0, 0);
      check("msb_72_mask", mask1, 8'h21);
      idx_valid_i = 1'b1;
      idx_i = 3'd1;
      idx_last_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d_mask", k), mask0, 8'h84);
         check($sformatf("hold%0d_cnt", k), cnt0, 2);
         check($sformatf("hold%0d_ready", k), rdy0, 0);
         check($sformatf("hold%0d_valid", k), val0, 1);
         check($sformatf("hold%0d_err", k), err2, 1);
      end
      idx_valid_i = 1'b0;
      idx_last_i = 1'b0;
      take();
      check("rel_ready", rdy0, 1);
      check("rel_mask", mask0, 0);
      check("rel_err", err2, 0);
      for (int k = 0; k < 8; k++) beat(3'(k), 1'b0, k == 7);
      check("full_mask", mask0, 8'hff);
      check("full_cnt", cnt0, 8);
      check("full_dup", dup0, 0);
      take();
      beat(3'd1, 1'b0, 1'b0);
      beat(3'd2, 1'b0, 1'b0);
      pulse_flush();
      check("flush_mask", mask0, 0);
      check("flush_cnt", cnt0, 0);
      beat(3'd5, 1'b0, 1'b1);
      check("after_flush_mask", mask0, 8'h20);
      check("after_flush_cnt", cnt0, 1);
      check("after_flush_valid", val0, 1);
      idx_valid_i = 1'b1;
      idx_i = 3'd4;
      idx_last_i = 1'b1;
      mask_ready_i = 1'b1;
      pulse_flush();
      check("flush_hold_valid", val0, 0);
      check("flush_hold_mask", mask0, 0);
      idx_valid_i = 1'b1;
      flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      idx_valid_i = 1'b0;
      idx_last_i = 1'b0;
      mask_ready_i = 1'b0;
      check("flush_beat_dropped", mask0, 0);
      check("flush_beat_valid", val0, 0);
      beat(3'd6, 1'b0, 1'b0);
      beat(3'd6, 1'b0, 1'b1);
      check("pre_rst_valid", val0, 1);
      check("pre_rst_dup", dup0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_hold_valid", val0, 0);
      check("rst_hold_mask", mask0, 0);
      check("rst_hold_cnt", cnt0, 0);
      check("rst_hold_dup", dup0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rel_ready", rdy0, 1);
      check("rst_rel_valid", val0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wired_mask_assemble.md
WIRED_MASK_ASSEMBLE -- requirements
Module: wired_mask_assemble

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the assembled mask, minimum 2.
REQ-002 SHALL have parameter MODE, default 1'b0: 0 means index i maps to mask bit i (from the LSB); 1 means it maps to bit WIDTH-1-i (from the MSB).
REQ-003 SHALL have derived parameter CNT_WIDTH = $clog2(WIDTH), not overridden: the index width.
REQ-004 SHALL have derived parameter POP_WIDTH = $clog2(WIDTH+1), not overridden: the set-bit count width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  the clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 flush_i  input  1  synchronous clear of all assembly state.
REQ-009 idx_valid_i  input  1  an index beat is offered.
REQ-010 idx_ready_o  output  1  the block accepts the beat this cycle.
REQ-011 idx_i  input  CNT_WIDTH  bit index, counted as defined by MODE.
REQ-012 idx_empty_i  input  1  the beat carries no index; idx_i is ignored.
REQ-013 idx_last_i  input  1  final beat of the current mask.
REQ-014 mask_valid_o  output  1  an assembled mask is presented.
REQ-015 mask_ready_i  input  1  the consumer takes the mask.
REQ-016 mask_o  output  WIDTH  the assembled mask.
REQ-017 mask_cnt_o  output  POP_WIDTH  number of set bits in mask_o.
REQ-018 mask_dup_o  output  1  at least one beat of this mask hit a bit that was already set.
REQ-019 mask_err_o  output  1  at least one beat of this mask had idx_i >= WIDTH.

Function
REQ-020 SHALL be a two-state FSM. ACCUM: idx_ready_o=1, mask_valid_o=0. HOLD: idx_ready_o=0, mask_valid_o=1.
REQ-021 Accept condition: idx_valid_i & idx_ready_o.
- On accept with idx_empty_i=0 and idx_i<WIDTH, SHALL OR the one-hot of the mapped bit into the accumulator.
REQ-022 On accept with idx_empty_i=1, accumulator bits SHALL be unchanged and no flag SHALL be raised.
REQ-023 On accept with idx_i>=WIDTH (WIDTH not a power of 2), SHALL leave the accumulator unchanged and set the sticky err flag.
REQ-024 On accept of an index whose bit is already set, SHALL set the sticky dup flag; count SHALL NOT increment.
REQ-025 Count SHALL increment by 1 per newly set bit and never exceed WIDTH.
REQ-026 On accept with idx_last_i=1, SHALL go ACCUM->HOLD; mask_valid_o rises the next cycle, and mask_o/cnt/flags include that last beat.
REQ-027 In HOLD, mask_o, mask_cnt_o, mask_dup_o and mask_err_o SHALL be stable until the handshake completes.
REQ-028 When mask_ready_i=1 in HOLD, SHALL go HOLD->ACCUM with accumulator, count and flags cleared; the next index is accepted the following cycle (no bypass).
REQ-029 Latency: last beat accepted at cycle N -> mask_valid_o=1 at N+1. Throughput is one mask per (beats+1) cycles at best.
REQ-030 In ACCUM, mask_o SHALL show the live accumulator, but mask_valid_o=0 means it is not valid for the consumer.
REQ-031 flush_i=1 SHALL take priority over every handshake: next state is ACCUM with everything cleared, and any beat or mask in flight that cycle is dropped.
REQ-032 idx_ready_o SHALL depend only on state, never combinationally on idx_valid_i or mask_ready_i.

Reset
REQ-033 When rst_n=0, SHALL asynchronously force state=ACCUM, mask_o=0, mask_cnt_o=0, mask_dup_o=0, mask_err_o=0 and mask_valid_o=0; idx_ready_o=1 once rst_n is released.
REQ-034 Reset mid-accumulation or in HOLD SHALL discard all partial and held data with no output handshake.

Verification
REQ-035 WIDTH=8, MODE=0, beats 0, 3(last) -> one cycle after the last beat: mask_o=0x09, cnt=2, dup=0, err=0.
REQ-036 WIDTH=8, MODE=1, beat 0(last) -> mask_o=0x80, cnt=1; beat empty(last) -> mask_o=0x00, cnt=0, valid=1.
REQ-037 WIDTH=8, beats 3, 3(last) -> mask_o=0x08, cnt=1, dup=1; WIDTH=6, beats 7, 2(last) -> mask_o=0x04, cnt=1, err=1.
REQ-038 WIDTH=8, mask held with mask_ready_i=0 for 5 cycles -> outputs stable and idx_ready_o=0 throughout; ready=1 -> ACCUM next cycle with mask_o=0.
REQ-039 Flush and reset: flush_i after beats 1, 2 -> next mask from beat 5(last) is 0x20; rst_n low in HOLD -> mask_valid_o=0 immediately and all outputs 0.
